// File: rtl/jtag_dmi_bridge.sv
// JTAG user-chain to DMI bridge: shifts {addr, data, op} from BSCANE2 strobes, issues one
// valid/ready request per Update-DR and reports RISC-V dmi status on the next Capture-DR.
module jtag_dmi_bridge #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    localparam int DR_W   = ADDR_W + DATA_W + 2
) (
    input  logic              jtag_tck,
    input  logic              jtag_trst_n,
    input  logic              jtag_sel,
    input  logic              jtag_capture,
    input  logic              jtag_shift,
    input  logic              jtag_update,
    input  logic              jtag_tdi,
    output logic              jtag_tdo,
    input  logic              sticky_clr,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [1:0]        req_op,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [1:0]        rsp_resp,
    input  logic [DATA_W-1:0] rsp_data,
    output logic              busy
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] STS_OK     = 2'd0;
    localparam logic [1:0] STS_FAILED = 2'd2;
    localparam logic [1:0] STS_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP
    } state_t;

    state_t            state;
    logic [DR_W-1:0]   sr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        sticky;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        capture_status;
    logic              sr_op_valid;

    assign jtag_tdo    = jtag_sel ? sr[0] : jtag_tdi;
    assign sr_op_valid = (sr[1:0] == OP_READ) || (sr[1:0] == OP_WRITE);

    // An outstanding request reads back as busy even before the overrun is recorded.
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        capture_status = STS_OK;
        if (busy || sticky == STS_BUSY) begin
            capture_status = STS_BUSY;
        end else if (sticky == STS_FAILED) begin
            capture_status = STS_FAILED;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; for sticky the last
    // assignment in program order wins, so the order is clear < failure < overrun.
    always_ff @(posedge jtag_tck) begin
        if (!jtag_trst_n) begin
            state      <= ST_IDLE;
            sr         <= '0;
            req_valid  <= 1'b0;
            rsp_ready  <= 1'b0;
            busy       <= 1'b0;
            req_op     <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            last_addr  <= '0;
            rsp_data_q <= '0;
            sticky     <= STS_OK;
            cnt        <= '0;
        end else begin
            if (sticky_clr) begin
                sticky <= STS_OK;
            end

            case (state)
                ST_IDLE: begin
                end
                ST_REQ: begin
                    if (req_ready) begin
                        state     <= ST_RSP;
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ST_RSP: begin
                    if (rsp_valid) begin
                        if (req_op == OP_READ) begin
                            rsp_data_q <= rsp_data;
                        end
                        if (rsp_resp != 2'd0) begin
                            sticky <= STS_FAILED;
                        end
                        state     <= ST_IDLE;
                        rsp_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                        sticky    <= STS_FAILED;
                        state     <= ST_IDLE;
                        rsp_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (jtag_sel) begin
                if (jtag_shift) begin
                    sr <= {jtag_tdi, sr[DR_W-1:1]};
                end else if (jtag_capture) begin
                    sr <= {last_addr, rsp_data_q, capture_status};
                end else if (jtag_update && sr_op_valid) begin
                    if (busy) begin
                        sticky <= STS_BUSY;
                    end else if (sticky == STS_OK) begin
                        req_op    <= sr[1:0];
                        req_data  <= sr[DATA_W+1:2];
                        req_addr  <= sr[DR_W-1:DATA_W+2];
                        last_addr <= sr[DR_W-1:DATA_W+2];
                        req_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
            end
        end
    end
endmodule
